// File: rtl/snitch_icache_pkg.sv
// Shared types for the L0 instruction-cache event counter: event strobes,
// event indices and the measurement FSM state.
package snitch_icache_pkg;

  localparam int unsigned EV_MISS       = 0;
  localparam int unsigned EV_HIT        = 1;
  localparam int unsigned EV_PREFETCH   = 2;
  localparam int unsigned EV_DOUBLE_HIT = 3;
  localparam int unsigned EV_STALL      = 4;
  localparam int unsigned NUM_EVENTS    = 5;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_events_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reorders the strobe struct into a vector indexed by the EV_* constants.
  function automatic logic [NUM_EVENTS-1:0] ev_vec(input icache_events_t ev);
    logic [NUM_EVENTS-1:0] v;
    v                = '0;
    v[EV_MISS]       = ev.l0_miss;
    v[EV_HIT]        = ev.l0_hit;
    v[EV_PREFETCH]   = ev.l0_prefetch;
    v[EV_DOUBLE_HIT] = ev.l0_double_hit;
    v[EV_STALL]      = ev.l0_stall;
    return v;
  endfunction

endpackage

// File: rtl/snitch_icache_sat_counter.sv
// Saturating event counter with synchronous clear; clear takes priority
// over increment so a start cycle never counts its own events.
module snitch_icache_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/snitch_icache_event_counter.sv
// Per-port L0 icache performance counters gated by a start/stop/window FSM,
// read back through a single-outstanding request/response port.
module snitch_icache_event_counter
  import snitch_icache_pkg::*;
#(
  parameter  int unsigned NR_FETCH_PORTS = 2,
  parameter  int unsigned CNT_W          = 32,
  parameter  int unsigned WINDOW_W       = 32,
  localparam int unsigned PORT_W         = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  icache_events_t [NR_FETCH_PORTS-1:0] events_i,
  input  logic                                start_i,
  input  logic                                stop_i,
  input  logic [WINDOW_W-1:0]                 window_i,
  output logic                                busy_o,
  output logic                                done_o,
  input  logic                                rd_valid_i,
  output logic                                rd_ready_o,
  input  logic [PORT_W-1:0]                   rd_port_i,
  input  logic [2:0]                          rd_event_i,
  output logic                                rd_rsp_valid_o,
  output logic [CNT_W-1:0]                    rd_rsp_data_o,
  output logic                                rd_rsp_err_o
);

  state_e              r_state, w_state_d;
  logic [WINDOW_W-1:0] r_remaining, w_remaining_d;
  logic                r_busy, r_done;
  logic                r_rsp_valid, r_rsp_err;
  logic [CNT_W-1:0]    r_rsp_data;

  logic                w_count_en;
  logic                w_rd_hit;
  logic [CNT_W-1:0]    w_rd_data;
  logic [CNT_W-1:0]    w_cnt [NR_FETCH_PORTS][NUM_EVENTS];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
      r_busy      <= (w_state_d == ST_RUN);
      r_done      <= (w_state_d == ST_DONE);
    end
  end

  // Next-state: start always wins; stop or the final window cycle ends RUN
  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_state_d     = ST_RUN;
          w_remaining_d = window_i;
        end
      end
      ST_RUN: begin
        if (start_i) begin
          w_remaining_d = window_i;
        end else begin
          if (r_remaining != '0) begin
            w_remaining_d = r_remaining - WINDOW_W'(1);
          end
          if (stop_i || (r_remaining == WINDOW_W'(1))) begin
            w_state_d = ST_DONE;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign w_count_en = (r_state == ST_RUN) && !start_i;

  for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_port
    logic [NUM_EVENTS-1:0] w_ev;
    assign w_ev = ev_vec(events_i[p]);
    for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_event
      snitch_icache_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_i),
        .inc_i (w_count_en && w_ev[e]),
        .cnt_o (w_cnt[p][e])
      );
    end
  end

  // Read mux; out-of-range indices match no entry and report an error
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
      for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
        if ((rd_port_i == PORT_W'(p)) && (rd_event_i == 3'(e))) begin
          w_rd_hit  = 1'b1;
          w_rd_data = w_cnt[p][e];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= rd_valid_i;
      r_rsp_data  <= (rd_valid_i && w_rd_hit) ? w_rd_data : '0;
      r_rsp_err   <= rd_valid_i && !w_rd_hit;
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign rd_ready_o     = 1'b1;
  assign rd_rsp_valid_o = r_rsp_valid;
  assign rd_rsp_data_o  = r_rsp_data;
  assign rd_rsp_err_o   = r_rsp_err;

endmodule
